// File: rtl/ram_writer_pkg.sv
// Shared types for the RAM pattern writer: data-pattern modes, FSM state encoding
// and the sizing helper for the delay/gap counter.
package ram_writer_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'b00,
        MODE_CONST = 2'b01,
        MODE_WALK  = 2'b10,
        MODE_ADDR  = 2'b11
    } ram_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_WAIT = 3'd1,
        ST_WRITE     = 3'd2,
        ST_GAP_WAIT  = 3'd3,
        ST_DONE      = 3'd4
    } ram_state_t;

    // The counter is loaded with (cycles - 1), so it only has to hold max(a, b) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ram_pattern_gen.sv
// Data for word index n: four selectable lane patterns, all lane arithmetic mod 2^LANE_W.
// Purely combinational; the caller registers the result.
module ram_pattern_gen
    import ram_writer_pkg::*;
#(
    parameter int LANE_W = 16,
    parameter int LANES  = 4,
    parameter int ADDR_W = 14,
    localparam int DATA_W = LANE_W * LANES
) (
    input  ram_mode_t           i_mode,
    input  logic [LANE_W-1:0]   i_seed,
    input  logic [ADDR_W:0]     i_n,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   o_data
);

    localparam int SW = LANE_W + ADDR_W + 2;
    localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);

    logic [SW-1:0]     w_sum;
    logic [SW-1:0]     w_sh;
    logic [LANE_W-1:0] w_lane;

    always_comb begin
        w_sum  = SW'(i_seed) + SW'(i_n);
        w_sh   = w_sum % SW'(LANE_W);
        w_lane = '0;
        o_data = '0;
        for (int k = 0; k < LANES; k++) begin
            case (i_mode)
                MODE_INC:   w_lane = i_seed + LANE_W'(i_n) * LANE_W'(LANES) + LANE_W'(k);
                MODE_CONST: w_lane = i_seed;
                MODE_WALK:  w_lane = LANE_ONE << w_sh;
                MODE_ADDR:  w_lane = LANE_W'(i_addr) * LANE_W'(LANES) + LANE_W'(k);
                default:    w_lane = '0;
            endcase
            o_data[k*LANE_W +: LANE_W] = w_lane;
        end
    end

endmodule

// File: rtl/ram_pattern_writer.sv
// RAM fill engine: writes i_count patterned words from i_base_addr, first strobe START_DELAY+1
// cycles after start, one word per 1+GAP cycles; a low i_ready holds the strobe, address and data.
module ram_pattern_writer
    import ram_writer_pkg::*;
#(
    parameter int LANE_W      = 16,
    parameter int LANES       = 4,
    parameter int ADDR_W      = 14,
    parameter int START_DELAY = 5,
    parameter int GAP         = 1,
    localparam int DATA_W     = LANE_W * LANES
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [ADDR_W:0]     i_count,
    input  logic [LANE_W-1:0]   i_seed,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic [DATA_W/8-1:0] o_byteen,
    output logic                o_wbit,
    output logic                o_busy,
    output logic                o_done
);

    localparam int CNT_W    = cnt_width(START_DELAY, GAP);
    localparam int DLY_LOAD = (START_DELAY > 0) ? START_DELAY - 1 : 0;
    localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [ADDR_W:0]   N_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    ram_state_t          r_state;
    ram_mode_t           r_mode;
    logic [LANE_W-1:0]   r_seed;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_wbit;
    logic                r_busy;
    logic                r_done;

    ram_state_t          w_state_nxt;
    ram_mode_t           w_mode_nxt;
    logic [LANE_W-1:0]   w_seed_nxt;
    logic [ADDR_W:0]     w_count_nxt;
    logic [ADDR_W:0]     w_n_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_gen_data;
    logic                w_start;
    logic                w_accept;
    logic                w_last;

    assign w_start  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
    assign w_accept = r_wbit && i_ready;
    assign w_last   = ((r_n + N_ONE) == r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_seed_nxt  = r_seed;
        w_count_nxt = r_count;
        w_n_nxt     = r_n;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_mode_nxt  = ram_mode_t'(i_mode);
                    w_seed_nxt  = i_seed;
                    w_count_nxt = i_count;
                    w_n_nxt     = '0;
                    w_addr_nxt  = i_base_addr;
                    w_cnt_nxt   = CNT_W'(DLY_LOAD);
                    // A zero-length run still spends one busy cycle in INIT_WAIT before DONE.
                    if ((i_count == '0) || (START_DELAY != 0)) begin
                        w_state_nxt = ST_INIT_WAIT;
                    end else begin
                        w_state_nxt = ST_WRITE;
                    end
                end
            end
            ST_INIT_WAIT: begin
                if (r_count == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_WRITE: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_n_nxt    = r_n + N_ONE;
                        w_addr_nxt = r_addr + A_ONE;
                        if (GAP == 0) begin
                            w_state_nxt = ST_WRITE;
                        end else begin
                            w_state_nxt = ST_GAP_WAIT;
                            w_cnt_nxt   = CNT_W'(GAP_LOAD);
                        end
                    end
                end
            end
            ST_GAP_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fed with next-cycle values so the data register lines up with the address register.
    ram_pattern_gen #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_gen (
        .i_mode (w_mode_nxt),
        .i_seed (w_seed_nxt),
        .i_n    (w_n_nxt),
        .i_addr (w_addr_nxt),
        .o_data (w_gen_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_INC;
            r_seed  <= '0;
            r_count <= '0;
            r_n     <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_wbit  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_seed  <= w_seed_nxt;
            r_count <= w_count_nxt;
            r_n     <= w_n_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start || w_accept) begin
                r_data <= w_gen_data;
            end
            r_wbit  <= (w_state_nxt == ST_WRITE);
            r_busy  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_data    = r_data;
    assign o_address = r_addr;
    assign o_byteen  = '1;
    assign o_wbit    = r_wbit;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: doc/ram_pattern_writer.md
# ram_pattern_writer

Parametrised RAM fill engine. It writes a programmable number of wide words into a single-port RAM through a write strobe with backpressure, using one of four data patterns. It sits between the control logic and the RAM write port and generalises the fixed 4×16-bit incrementing writer. It adds a start/busy/done handshake, a configurable base address and length, RAM-ready backpressure, and configurable inter-write gap.

## Interface
- `LANE_W`, 16: width of one data lane (multiple of 8)
- `LANES`, 4: lanes per RAM word; word width `DATA_W = LANE_W*LANES`
- `ADDR_W`, 14: RAM address width
- `START_DELAY`, 5: idle cycles between accepted start and first write (0 allowed)
- `GAP`, 1: cycles with `o_wbit`=0 after each accepted write (0 = back-to-back)

Ports:
- `i_clk` in 1: single clock, all logic on rising edge
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_start` in 1: start pulse, sampled only in IDLE or DONE
- `i_mode` in 2: 00 increment, 01 constant, 10 walking-one, 11 address-as-data; latched at start
- `i_base_addr` in ADDR_W: first address, latched at start
- `i_count` in ADDR_W+1: number of words to write, latched at start
- `i_seed` in LANE_W: pattern seed, latched at start
- `i_ready` in 1: RAM accepts a write on this edge
- `o_data` out DATA_W: write data, lane k at bits `[k*LANE_W +: LANE_W]`
- `o_address` out ADDR_W: write address
- `o_byteen` out DATA_W/8: byte enables, constant all-ones
- `o_wbit` out 1: write strobe
- `o_busy` out 1: high from accepted start until DONE
- `o_done` out 1: high in DONE, held until the next start or reset

## Operation
- States: IDLE, INIT_WAIT, WRITE, GAP_WAIT, DONE.
- IDLE/DONE + `i_start`: latch inputs, set index n=0, set `o_busy`=1, clear `o_done`. Go to INIT_WAIT, or directly to WRITE if `START_DELAY`=0.
- `i_count`=0 at start: go straight to DONE. No write is issued. `o_busy` is high for exactly one cycle.
- INIT_WAIT: count `START_DELAY` cycles, then go to WRITE.
- WRITE: `o_wbit`=1 with the address and data for index n. A write is accepted at an edge where `o_wbit`&`i_ready`.
  - Not accepted: hold address and data stable and keep `o_wbit` high.
  - Accepted with n=count-1: go to DONE.
  - Accepted otherwise: n++, then go to GAP_WAIT, or stay in WRITE if `GAP`=0.
- GAP_WAIT: `o_wbit`=0 for `GAP` cycles, then go to WRITE.
- `i_start` outside IDLE/DONE is ignored. Input changes while busy have no effect.
- Address: `base + n` mod 2^ADDR_W. It wraps silently past the top of the RAM.
- Data, lane k, all values mod 2^LANE_W:
  - increment: `seed + n*LANES + k`. With seed 0 the words are 0,1,2,3 then 4,5,6,7, and so on.
  - constant: `seed` in every lane.
  - walking-one: `1 << ((seed + n) mod LANE_W)` in every lane.
  - address-as-data: `o_address*LANES + k`.
- Reset (any time, including mid-write): state goes to IDLE. All outputs go to 0 except `o_byteen`, which is all-ones. No partial strobe is permitted after reset assertion.

## Timing
- Start accepted at edge T0. The first `o_wbit` rises after edge T0+`START_DELAY`, i.e. `START_DELAY`+1 cycles after the start edge.
- With `i_ready` held high, the write period is `1+GAP` cycles. N words finish at edge T0+`START_DELAY`+N(1+GAP)-GAP.
- `o_done` rises the cycle after the last accepted write. `o_busy` falls in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `ram_writer_pkg`: mode constants, state encoding, and the `ram_mode_t` typedef.
- Sub-module `ram_pattern_gen`: combinational function of (mode, seed, n, address) producing `DATA_W` data. Instantiated once.
- Top level: FSM, delay/gap counter, index counter (ADDR_W+1 bits), output registers.

## Test plan
- Defaults, mode 00, seed 0, base 0, count 3, `i_ready`=1 -> addresses 0,1,2 with data 0x0003_0002_0001_0000, 0x0007_0006_0005_0004, 0x000B_000A_0009_0008. Strobes are 2 cycles apart; `o_done` rises one cycle after the third write.
- Mode 00, base 0x3FFE, count 4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; no error.
- `i_ready` low for 3 cycles during write 1 -> `o_wbit`, address and data held 4 cycles; exactly 3 accepted writes total.
- Count 0 -> no `o_wbit`; `o_busy` high 1 cycle; `o_done`=1. Mode 10, seed 15, count 2 -> lanes 0x8000, then 0x0001.
- `i_rst_n` low mid-write -> `o_wbit`=0 asynchronously and state is IDLE. A later start runs cleanly from n=0. A start issued while busy is ignored.
